// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage 8-bit pipeline: load-use, branch/RET redirects, interrupt entry.
// Define PIPE_HAZARD_CTRL_INTR_EN to build the interrupt-entry path (INT_* states, save_pc, intr_vec_sel, intr_ack).
module pipe_hazard_ctrl #(
   parameter int RET_FLUSH_CYC = 2,
   parameter int INT_DRAIN_CYC = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rd_en_E,
   input  logic [1:0] rd_E,
   input  logic [1:0] ra_D,
   input  logic [1:0] rb_D,
   input  logic       uses_ra_D,
   input  logic       uses_rb_D,
   input  logic       branch_taken_E,
   input  logic       is_ret_M,
   input  logic       intr_req,
   output logic       stall_F,
   output logic       stall_D,
   output logic       flush_D,
   output logic       flush_E,
   output logic       flush_M,
   output logic       save_pc,
   output logic       intr_vec_sel,
   output logic       intr_ack
);

`ifdef PIPE_HAZARD_CTRL_INTR_EN
   typedef enum logic [2:0] {RUN, RET_WAIT, INT_DRAIN, INT_PUSH, INT_VEC} state_t;
   localparam logic [7:0] INT_RELOAD = 8'(INT_DRAIN_CYC - 1);
`else
   typedef enum logic [2:0] {RUN, RET_WAIT} state_t;
   logic unused_intr_req;
   assign unused_intr_req = intr_req;
`endif
   localparam logic [7:0] RET_RELOAD = 8'(RET_FLUSH_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cnt_dec;
   logic       luh;
   logic       stall_f_c, stall_d_c, flush_d_c, flush_e_c, flush_m_c;
   logic       save_pc_c, intr_vec_sel_c, intr_ack_c;

   assign luh     = rd_en_E & ((uses_ra_D & (ra_D == rd_E)) | (uses_rb_D & (rb_D == rd_E)));
   assign cnt_dec = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stall_f_c      = 1'b0;
      stall_d_c      = 1'b0;
      flush_d_c      = 1'b0;
      flush_e_c      = 1'b0;
      flush_m_c      = 1'b0;
      save_pc_c      = 1'b0;
      intr_vec_sel_c = 1'b0;
      intr_ack_c     = 1'b0;
      case (state_q)
         RUN: begin
            if (is_ret_M) begin
               flush_d_c = 1'b1;
               flush_e_c = 1'b1;
               flush_m_c = 1'b1;
               state_d   = RET_WAIT;
               cnt_d     = RET_RELOAD;
            end else if (branch_taken_E) begin
               flush_d_c = 1'b1;
               flush_e_c = 1'b1;
            end else if (luh) begin
               stall_f_c = 1'b1;
               stall_d_c = 1'b1;
               flush_e_c = 1'b1;
`ifdef PIPE_HAZARD_CTRL_INTR_EN
            end else if (intr_req) begin
               state_d = INT_DRAIN;
               cnt_d   = INT_RELOAD;
`endif
            end
         end
         RET_WAIT: begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            cnt_d     = cnt_dec;
            if (cnt_q == 8'd0) state_d = RUN;
         end
`ifdef PIPE_HAZARD_CTRL_INTR_EN
         // A redirect during drain restarts it so the redirected PC is the one pushed.
         INT_DRAIN: begin
            stall_f_c = 1'b1;
            flush_d_c = 1'b1;
            if (is_ret_M) begin
               flush_e_c = 1'b1;
               flush_m_c = 1'b1;
               cnt_d     = INT_RELOAD;
            end else if (branch_taken_E) begin
               flush_e_c = 1'b1;
               cnt_d     = INT_RELOAD;
            end else begin
               cnt_d = cnt_dec;
               if (cnt_q == 8'd0) state_d = INT_PUSH;
            end
         end
         INT_PUSH: begin
            save_pc_c = 1'b1;
            stall_f_c = 1'b1;
            flush_d_c = 1'b1;
            state_d   = INT_VEC;
         end
         INT_VEC: begin
            intr_vec_sel_c = 1'b1;
            intr_ack_c     = 1'b1;
            flush_d_c      = 1'b1;
            state_d        = RUN;
         end
`endif
         default: begin
            state_d = RUN;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated by reset so nothing leaks while it is held low.
   assign stall_F      = reset & stall_f_c;
   assign stall_D      = reset & stall_d_c;
   assign flush_D      = reset & flush_d_c;
   assign flush_E      = reset & flush_e_c;
   assign flush_M      = reset & flush_m_c;
   assign save_pc      = reset & save_pc_c;
   assign intr_vec_sel = reset & intr_vec_sel_c;
   assign intr_ack     = reset & intr_ack_c;

endmodule
